// File: rtl/itch_multi_decoder.sv
// ITCH 5.0 multi-type message framer: frames A/X/D/U/E messages from a byte stream,
// emits the raw payload as soon as its length is reached and flags malformed frames.
module itch_multi_decoder #(
  parameter logic [4:0] TYPE_EN = 5'b11111,
  parameter int         MAX_LEN = 36,
  parameter int         COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_in,
  input  logic                 valid_in,
  output logic                 out_valid,
  output logic [7:0]           out_type,
  output logic [5:0]           out_len,
  output logic [MAX_LEN*8-1:0] out_payload,
  output logic                 packet_invalid,
  output logic [COUNT_W-1:0]   good_count,
  output logic [COUNT_W-1:0]   err_count
);

  localparam int PW = MAX_LEN * 8;

  localparam int LEN_A = TYPE_EN[0] ? 36 : 0;
  localparam int LEN_X = TYPE_EN[1] ? 23 : 0;
  localparam int LEN_D = TYPE_EN[2] ? 19 : 0;
  localparam int LEN_U = TYPE_EN[3] ? 35 : 0;
  localparam int LEN_E = TYPE_EN[4] ? 31 : 0;
  localparam int MAX_AX  = (LEN_A > LEN_X) ? LEN_A : LEN_X;
  localparam int MAX_DU  = (LEN_D > LEN_U) ? LEN_D : LEN_U;
  localparam int MAX_AXDU = (MAX_AX > MAX_DU) ? MAX_AX : MAX_DU;
  localparam int MAX_EN_LEN = (MAX_AXDU > LEN_E) ? MAX_AXDU : LEN_E;

  generate
    if (MAX_LEN < MAX_EN_LEN) begin : g_bad_max_len
      $error("itch_multi_decoder: MAX_LEN smaller than longest enabled message type");
    end
  endgenerate

  typedef enum logic [1:0] {
    GAP_WAIT = 2'd0,
    IDLE     = 2'd1,
    COLLECT  = 2'd2,
    FULL     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [5:0]           len_q, len_d;
  logic [PW-1:0]        buf_q, buf_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_type_q, out_type_d;
  logic [5:0]           out_len_q, out_len_d;
  logic [PW-1:0]        out_payload_q, out_payload_d;
  logic                 packet_invalid_q, packet_invalid_d;
  logic [COUNT_W-1:0]   good_count_q, good_count_d;
  logic [COUNT_W-1:0]   err_count_q, err_count_d;

  // Zero length doubles as "unknown or disabled type".
  function automatic logic [5:0] type_len(input logic [7:0] t);
    case (t)
      8'h41:   type_len = 6'(LEN_A);
      8'h58:   type_len = 6'(LEN_X);
      8'h44:   type_len = 6'(LEN_D);
      8'h55:   type_len = 6'(LEN_U);
      8'h45:   type_len = 6'(LEN_E);
      default: type_len = 6'd0;
    endcase
  endfunction

  logic [5:0] in_len;
  logic       start_msg;
  logic       buf_clr;
  logic       buf_we;
  logic [5:0] wr_idx;

  // Buffer write controls depend only on registered state so the FSM can consume buf_d.
  assign in_len    = type_len(byte_in);
  assign start_msg = (state_q == IDLE) && valid_in && (in_len != 6'd0);
  assign buf_clr   = start_msg;
  assign buf_we    = start_msg || ((state_q == COLLECT) && valid_in);
  assign wr_idx    = (state_q == IDLE) ? 6'd0 : cnt_q;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_byte
      assign buf_d[PW-1-8*gi -: 8] =
        (buf_we && (wr_idx == 6'(gi))) ? byte_in :
        (buf_clr ? 8'h00 : buf_q[PW-1-8*gi -: 8]);
    end
  endgenerate

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    len_d            = len_q;
    out_valid_d      = 1'b0;
    packet_invalid_d = 1'b0;
    out_type_d       = out_type_q;
    out_len_d        = out_len_q;
    out_payload_d    = out_payload_q;

    case (state_q)
      GAP_WAIT: begin
        if (!valid_in) state_d = IDLE;
      end
      IDLE: begin
        if (valid_in) begin
          if (in_len != 6'd0) begin
            cnt_d   = 6'd1;
            len_d   = in_len;
            state_d = COLLECT;
          end else begin
            packet_invalid_d = 1'b1;
            state_d          = GAP_WAIT;
          end
        end
      end
      COLLECT: begin
        if (valid_in) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) begin
            out_valid_d   = 1'b1;
            out_type_d    = buf_q[PW-1 -: 8];
            out_len_d     = len_q;
            out_payload_d = buf_d;
            state_d       = FULL;
          end
        end else begin
          // The dropping cycle already serves as the inter-message gap.
          packet_invalid_d = 1'b1;
          state_d          = IDLE;
        end
      end
      FULL: begin
        if (valid_in) begin
          packet_invalid_d = 1'b1;
          state_d          = GAP_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = GAP_WAIT;
    endcase

    good_count_d = good_count_q;
    if (out_valid_d && (good_count_q != {COUNT_W{1'b1}}))
      good_count_d = good_count_q + COUNT_W'(1);
    err_count_d = err_count_q;
    if (packet_invalid_d && (err_count_q != {COUNT_W{1'b1}}))
      err_count_d = err_count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= GAP_WAIT;
      cnt_q            <= '0;
      len_q            <= '0;
      buf_q            <= '0;
      out_valid_q      <= 1'b0;
      out_type_q       <= '0;
      out_len_q        <= '0;
      out_payload_q    <= '0;
      packet_invalid_q <= 1'b0;
      good_count_q     <= '0;
      err_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      len_q            <= len_d;
      buf_q            <= buf_d;
      out_valid_q      <= out_valid_d;
      out_type_q       <= out_type_d;
      out_len_q        <= out_len_d;
      out_payload_q    <= out_payload_d;
      packet_invalid_q <= packet_invalid_d;
      good_count_q     <= good_count_d;
      err_count_q      <= err_count_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_type       = out_type_q;
  assign out_len        = out_len_q;
  assign out_payload    = out_payload_q;
  assign packet_invalid = packet_invalid_q;
  assign good_count     = good_count_q;
  assign err_count      = err_count_q;

endmodule
